// File: rtl/rv_core_pkg.sv
// Shared constants and helpers for the RV32I core front end.
package rv_core_pkg;

  localparam int          XLEN_DEF     = 32;
  localparam int          INST_W       = 32;
  localparam logic [63:0] RESET_PC_DEF = 64'h0;
  localparam logic [31:0] NOP_INST     = 32'h0000_0013;

  // What happens to an incoming memory response in a given cycle.
  typedef enum logic [1:0] {
    RSP_IDLE,
    RSP_FILL,
    RSP_SQUASH,
    RSP_STRAY
  } rsp_act_e;

  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rv_fetch_queue.sv
// Fetch queue: DEPTH entries of {pc, data, filled} tracked by alloc/fill/head
// pointers that carry an extra wrap bit.
module rv_fetch_queue
  import rv_core_pkg::*;
#(
  parameter  int XLEN  = XLEN_DEF,
  parameter  int DEPTH = 4,
  localparam int AW    = clog2(DEPTH),
  localparam int PW    = AW + 1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              flush,
  input  logic              alloc_en,
  input  logic [XLEN-1:0]   alloc_pc,
  input  logic              fill_en,
  input  logic [INST_W-1:0] fill_data,
  input  logic              pop_en,
  output logic [PW-1:0]     occupancy,
  output logic [PW-1:0]     outstanding,
  output logic              full,
  output logic              head_filled,
  output logic [XLEN-1:0]   head_pc,
  output logic [INST_W-1:0] head_data
);

  logic [PW-1:0]     alloc_ptr_q, alloc_ptr_d;
  logic [PW-1:0]     fill_ptr_q, fill_ptr_d;
  logic [PW-1:0]     head_ptr_q, head_ptr_d;
  logic [DEPTH-1:0]  filled_q, filled_d;
  logic [XLEN-1:0]   pc_q   [DEPTH];
  logic [XLEN-1:0]   pc_d   [DEPTH];
  logic [INST_W-1:0] data_q [DEPTH];
  logic [INST_W-1:0] data_d [DEPTH];

  logic [AW-1:0] alloc_idx, fill_idx, head_idx;

  assign alloc_idx = alloc_ptr_q[AW-1:0];
  assign fill_idx  = fill_ptr_q[AW-1:0];
  assign head_idx  = head_ptr_q[AW-1:0];

  assign occupancy   = alloc_ptr_q - head_ptr_q;
  assign outstanding = alloc_ptr_q - fill_ptr_q;
  assign full        = (occupancy == PW'(DEPTH));
  assign head_filled = filled_q[head_idx];
  assign head_pc     = pc_q[head_idx];
  assign head_data   = data_q[head_idx];

  // Alloc, fill and pop never target the same slot in one cycle: fill trails
  // alloc and a pop needs an already-filled slot, so the order below is free.
  always_comb begin
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    filled_d    = filled_q;
    pc_d        = pc_q;
    data_d      = data_q;
    if (flush) begin
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      filled_d    = '0;
    end else begin
      if (pop_en) begin
        filled_d[head_idx] = 1'b0;
        head_ptr_d         = head_ptr_q + PW'(1);
      end
      if (fill_en) begin
        filled_d[fill_idx] = 1'b1;
        data_d[fill_idx]   = fill_data;
        fill_ptr_d         = fill_ptr_q + PW'(1);
      end
      if (alloc_en) begin
        filled_d[alloc_idx] = 1'b0;
        pc_d[alloc_idx]     = alloc_pc;
        alloc_ptr_d         = alloc_ptr_q + PW'(1);
      end
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      filled_q    <= '0;
    end else begin
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      filled_q    <= filled_d;
    end
  end

  // Payload storage is qualified by the filled flags and needs no reset.
  always_ff @(posedge CLK) begin
    pc_q   <= pc_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/rv_fetch_unit.sv
// Decoupled RV32I fetch stage: fetch_pc, redirect and squash control around a
// fetch queue. Optional performance counters are built when FETCH_PERF_EN is defined.
module rv_fetch_unit
  import rv_core_pkg::*;
#(
  parameter int              XLEN     = XLEN_DEF,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = XLEN'(RESET_PC_DEF)
) (
  input  logic              CLK,
  input  logic              RST,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [XLEN-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  input  logic              redir_valid,
  input  logic [XLEN-1:0]   redir_pc,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst_data,
  output logic [XLEN-1:0]   inst_pc,
  output logic              busy
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_squash_cnt
`endif
);

  localparam int PW = clog2(DEPTH) + 1;
  localparam int CW = PW + 1;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [PW-1:0]   squash_cnt_q, squash_cnt_d;

  logic [PW-1:0] occupancy, outstanding;
  logic          full, head_filled;
  logic [CW-1:0] total_out;
  logic          issue_ok, req_fire, pop_fire, squash_dec;
  rsp_act_e      rsp_act;
  logic          unused_redir_lsb;

  assign unused_redir_lsb = ^redir_pc[1:0];

  rv_fetch_queue #(
    .XLEN  (XLEN),
    .DEPTH (DEPTH)
  ) u_queue (
    .CLK         (CLK),
    .RST         (RST),
    .flush       (redir_valid),
    .alloc_en    (req_fire),
    .alloc_pc    (fetch_pc_q),
    .fill_en     (rsp_act == RSP_FILL),
    .fill_data   (imem_rsp_data),
    .pop_en      (pop_fire),
    .occupancy   (occupancy),
    .outstanding (outstanding),
    .full        (full),
    .head_filled (head_filled),
    .head_pc     (inst_pc),
    .head_data   (inst_data)
  );

  // Squashed requests still occupy memory slots, so they count toward the cap.
  assign total_out = CW'(outstanding) + CW'(squash_cnt_q);
  assign issue_ok  = ~full & ((CW'(occupancy) + CW'(squash_cnt_q)) < CW'(DEPTH));

  // Gating with RST forces the request low asynchronously while in reset.
  assign imem_req_valid = RST & issue_ok & ~redir_valid;
  assign imem_req_addr  = fetch_pc_q;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign inst_valid     = head_filled & ~redir_valid;
  assign pop_fire       = inst_valid & inst_ready;
  assign busy           = (outstanding != '0) | (squash_cnt_q != '0);

  always_comb begin
    rsp_act = RSP_IDLE;
    if (imem_rsp_valid) begin
      if (total_out == '0)                           rsp_act = RSP_STRAY;
      else if (redir_valid || (squash_cnt_q != '0)) rsp_act = RSP_SQUASH;
      else                                           rsp_act = RSP_FILL;
    end
  end

  assign squash_dec = (rsp_act == RSP_SQUASH);

  // A response landing in the redirect cycle retires one of the old requests.
  always_comb begin
    fetch_pc_d   = fetch_pc_q;
    squash_cnt_d = squash_cnt_q;
    if (redir_valid) begin
      fetch_pc_d   = {redir_pc[XLEN-1:2], 2'b00};
      squash_cnt_d = PW'(total_out - CW'(squash_dec));
    end else begin
      if (req_fire)   fetch_pc_d   = fetch_pc_q + XLEN'(4);
      if (squash_dec) squash_cnt_d = squash_cnt_q - PW'(1);
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      fetch_pc_q   <= RESET_PC;
      squash_cnt_q <= '0;
    end else begin
      fetch_pc_q   <= fetch_pc_d;
      squash_cnt_q <= squash_cnt_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [31:0] perf_squash_q, perf_squash_d;

  always_comb begin
    perf_stall_d  = perf_stall_q;
    perf_squash_d = perf_squash_q;
    if (inst_ready && !inst_valid && (perf_stall_q != '1))
      perf_stall_d = perf_stall_q + 32'd1;
    if (squash_dec && (perf_squash_q != '1))
      perf_squash_d = perf_squash_q + 32'd1;
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      perf_stall_q  <= '0;
      perf_squash_q <= '0;
    end else begin
      perf_stall_q  <= perf_stall_d;
      perf_squash_q <= perf_squash_d;
    end
  end

  assign perf_stall_cnt  = perf_stall_q;
  assign perf_squash_cnt = perf_squash_q;
`endif

`ifndef SYNTHESIS
  stray_rsp_a: assert property (@(posedge CLK) disable iff (!RST)
    imem_rsp_valid |-> (rsp_act != RSP_STRAY));
`endif

endmodule

// File: tb/tb_rv_fetch_unit.sv
// Directed bench for rv_fetch_unit with a fixed-latency instruction memory model.
module tb_rv_fetch_unit;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst_data;
  logic [31:0] inst_pc;
  logic        busy;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_stall_cnt;
  logic [31:0] perf_squash_cnt;
`endif

  int vectors     = 0;
  int miscompares = 0;

  always #5 CLK = ~CLK;

  rv_fetch_unit #(
    .XLEN     (32),
    .DEPTH    (4),
    .RESET_PC (32'h100)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redir_valid    (redir_valid),
    .redir_pc       (redir_pc),
    .inst_valid     (inst_valid),
    .inst_ready     (inst_ready),
    .inst_data      (inst_data),
    .inst_pc        (inst_pc),
    .busy           (busy)
`ifdef FETCH_PERF_EN
    ,
    .perf_stall_cnt  (perf_stall_cnt),
    .perf_squash_cnt (perf_squash_cnt)
`endif
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  // Memory model: accepted request appears as a response lat cycles later.
  int          lat = 1;
  logic        pv [4];
  logic [31:0] pa [4];
  logic        acc_n;
  logic [31:0] addr_n;

  always @(negedge CLK) begin
    acc_n  = imem_req_valid & imem_req_ready;
    addr_n = imem_req_addr;
  end

  always @(posedge CLK or negedge RST) begin
    if (!RST) begin
      for (int i = 0; i < 4; i++) begin
        pv[i] <= 1'b0;
        pa[i] <= '0;
      end
    end else begin
      pv[0] <= acc_n;
      pa[0] <= addr_n;
      for (int i = 1; i < 4; i++) begin
        pv[i] <= pv[i-1];
        pa[i] <= pa[i-1];
      end
    end
  end

  always_comb begin
    imem_rsp_valid = pv[lat-1];
    imem_rsp_data  = mem_word(pa[lat-1]);
  end

  // Handshake logs, sampled mid-cycle.
  logic [31:0] req_log [$];
  logic [63:0] pop_log [$];

  always @(negedge CLK) begin
    if (RST && imem_req_valid && imem_req_ready) req_log.push_back(imem_req_addr);
    if (RST && inst_valid && inst_ready)         pop_log.push_back({inst_pc, inst_data});
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic do_reset(input int latency, input logic rdy);
    RST         = 1'b0;
    redir_valid = 1'b0;
    redir_pc    = '0;
    inst_ready  = rdy;
    lat         = latency;
    req_log.delete();
    pop_log.delete();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    imem_req_ready = 1'b1;
    redir_valid    = 1'b0;
    redir_pc       = '0;
    inst_ready     = 1'b1;

    // Reset values.
    RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_req_valid", 64'(imem_req_valid), 64'd0);
    chk("rst_inst_valid", 64'(inst_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // 1: latency 1 streaming.
    do_reset(1, 1'b1);
    chk("t1_req_valid", 64'(imem_req_valid), 64'd1);
    chk("t1_req_addr", 64'(imem_req_addr), 64'h100);
    chk("t1_inst_valid_c0", 64'(inst_valid), 64'd0);
    step();
    chk("t1_inst_valid_c1", 64'(inst_valid), 64'd0);
    chk("t1_busy_c1", 64'(busy), 64'd1);
`ifdef FETCH_PERF_EN
    chk("t1_perf_stall", 64'(perf_stall_cnt), 64'd1);
`endif
    step();
    chk("t1_inst_valid_c2", 64'(inst_valid), 64'd1);
    chk("t1_inst_pc_c2", 64'(inst_pc), 64'h100);
    chk("t1_inst_data_c2", 64'(inst_data), 64'hC0DE0100);
    repeat (6) step();
    chk("t1_req_cnt_ge6", 64'(req_log.size() >= 6), 64'd1);
    for (int i = 0; i < 6; i++)
      chk($sformatf("t1_req%0d", i), 64'(req_log[i]), 64'h100 + 64'(4 * i));
    for (int i = 0; i < 4; i++)
      chk($sformatf("t1_pop%0d", i), pop_log[i],
          {32'h100 + 32'(4 * i), 32'hC0DE0100 + 32'(4 * i)});

    // 2: decode stalled fills the queue, then drains in order.
    do_reset(1, 1'b0);
    repeat (5) step();
    chk("t2_req_valid_full", 64'(imem_req_valid), 64'd0);
    chk("t2_req_cnt", 64'(req_log.size()), 64'd4);
    chk("t2_inst_valid", 64'(inst_valid), 64'd1);
    chk("t2_inst_pc", 64'(inst_pc), 64'h100);
    inst_ready = 1'b1;
    repeat (6) step();
    for (int i = 0; i < 4; i++)
      chk($sformatf("t2_pop%0d", i), pop_log[i],
          {32'h100 + 32'(4 * i), 32'hC0DE0100 + 32'(4 * i)});
    chk("t2_req4", 64'(req_log[4]), 64'h110);

    // 3: latency 3, redirect with three requests in flight.
    do_reset(3, 1'b1);
    repeat (3) step();
    chk("t3_busy_pre", 64'(busy), 64'd1);
    chk("t3_req_valid_pre", 64'(imem_req_valid), 64'd1);
    redir_valid = 1'b1;
    redir_pc    = 32'h203;
    #1;
    chk("t3_req_valid_redir", 64'(imem_req_valid), 64'd0);
    step();
    redir_valid = 1'b0;
    #1;
    chk("t3_req_valid_post", 64'(imem_req_valid), 64'd1);
    chk("t3_req_addr_post", 64'(imem_req_addr), 64'h200);
    chk("t3_busy_post", 64'(busy), 64'd1);
    repeat (3) step();
    chk("t3_no_stale_pop", 64'(pop_log.size()), 64'd0);
    step();
    chk("t3_inst_valid", 64'(inst_valid), 64'd1);
    chk("t3_inst_pc", 64'(inst_pc), 64'h200);
    chk("t3_inst_data", 64'(inst_data), 64'hC0DE0200);
`ifdef FETCH_PERF_EN
    chk("t3_perf_squash", 64'(perf_squash_cnt), 64'd3);
`endif

    // 4: redirect coincides with a response and a poppable head.
    do_reset(2, 1'b1);
    repeat (3) step();
    chk("t4_head_valid", 64'(inst_valid), 64'd1);
    chk("t4_head_pc", 64'(inst_pc), 64'h100);
    redir_valid = 1'b1;
    redir_pc    = 32'h300;
    #1;
    chk("t4_inst_valid_redir", 64'(inst_valid), 64'd0);
    chk("t4_req_valid_redir", 64'(imem_req_valid), 64'd0);
    chk("t4_busy_redir", 64'(busy), 64'd1);
    step();
    redir_valid = 1'b0;
    #1;
    chk("t4_busy_squash", 64'(busy), 64'd1);
    chk("t4_req_addr", 64'(imem_req_addr), 64'h300);
    chk("t4_inst_valid_squash", 64'(inst_valid), 64'd0);
    repeat (3) step();
    chk("t4_no_pop_before", 64'(pop_log.size()), 64'd0);
    chk("t4_inst_pc", 64'(inst_pc), 64'h300);
    chk("t4_inst_data", 64'(inst_data), 64'hC0DE0300);

    // 5: PC wrap and redirect target alignment.
    do_reset(1, 1'b1);
    redir_valid = 1'b1;
    redir_pc    = 32'hFFFF_FFFE;
    #1;
    chk("t5_req_valid_redir", 64'(imem_req_valid), 64'd0);
    step();
    redir_valid = 1'b0;
    #1;
    chk("t5_req_addr_top", 64'(imem_req_addr), 64'hFFFF_FFFC);
    step();
    chk("t5_req_addr_wrap", 64'(imem_req_addr), 64'h0);
    step();
    chk("t5_inst_pc_top", 64'(inst_pc), 64'hFFFF_FFFC);
    step();
    chk("t5_inst_pc_wrap", 64'(inst_pc), 64'h0);
    chk("t5_inst_data_wrap", 64'(inst_data), 64'hC0DE0000);

    // 6: asynchronous reset with two requests outstanding.
    do_reset(3, 1'b1);
    repeat (2) step();
    chk("t6_busy_pre", 64'(busy), 64'd1);
    RST = 1'b0;
    #1;
    chk("t6_req_valid_rst", 64'(imem_req_valid), 64'd0);
    chk("t6_inst_valid_rst", 64'(inst_valid), 64'd0);
    chk("t6_busy_rst", 64'(busy), 64'd0);
`ifdef FETCH_PERF_EN
    chk("t6_perf_stall_rst", 64'(perf_stall_cnt), 64'd0);
    chk("t6_perf_squash_rst", 64'(perf_squash_cnt), 64'd0);
`endif
    req_log.delete();
    pop_log.delete();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1;
    #1;
    chk("t6_req_valid_rel", 64'(imem_req_valid), 64'd1);
    chk("t6_req_addr_rel", 64'(imem_req_addr), 64'h100);
    repeat (5) step();
    chk("t6_first_pop", pop_log[0], {32'h100, 32'hC0DE0100});

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
